// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision constants and helpers.
// Used by the divider beside the combinational multiplier.
package fpu_pkg;

    localparam logic [31:0] FP_QNAN     = 32'h7fc00000;
    localparam logic [31:0] FP_NEG_QNAN = 32'hffc00000;
    localparam logic [31:0] FP_INF      = 32'h7f800000;
    localparam int          FP_BIAS     = 127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SETUP,
        S_DIVIDE,
        S_NORMALIZE,
        S_ROUND,
        S_DONE
    } fdiv_state_e;

    function automatic logic is_nan(input logic [31:0] f);
        return (&f[30:23]) && (|f[22:0]);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (&f[30:23]) && !(|f[22:0]);
    endfunction

    function automatic logic is_zero(input logic [31:0] f);
        return !(|f[30:0]);
    endfunction

    // Position of the leading one counted from bit 23.
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (m[i]) n = 5'(23 - i);
        return n;
    endfunction

    // Carry out of the fraction ripples into the exponent field.
    function automatic logic [30:0] round_to_nearest_even(
        input logic [30:0] mag,
        input logic        g,
        input logic        s
    );
        return mag + 31'(g & (s | mag[0]));
    endfunction

endpackage

// File: rtl/float_divider_seq_if.sv
// float_divider_seq_if: start/busy/done handshake and operand bus.
// master drives operands, slave returns the quotient.
interface float_divider_seq_if;

    logic        start;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] fz;
    logic        busy;
    logic        done;

    modport master (
        output start, fa, fb,
        input  fz, busy, done
    );

    modport slave (
        input  start, fa, fb,
        output fz, busy, done
    );

endinterface

// File: rtl/fdiv_restoring_step.sv
// fdiv_restoring_step: one restoring quotient bit.
// Combinational; chained twice for two bits per cycle.
module fdiv_restoring_step #(
    parameter int W = 26
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] div,
    output logic [W-1:0] rem_nxt,
    output logic         q
);

    logic [W-1:0] trial;

    assign trial   = rem - div;
    assign q       = ~trial[W-1];
    assign rem_nxt = (q ? trial : rem) << 1;

endmodule

// File: rtl/float_divider_seq.sv
// float_divider_seq: multi-cycle IEEE-754 single divider, fz = fa / fb.
// Define FDIV_RADIX4_EN to retire two quotient bits per DIVIDE cycle.
module float_divider_seq
    import fpu_pkg::*;
#(
    parameter int ITER  = 26,
    parameter int EXP_W = 10
) (
    input logic                clk,
    input logic                clr,
    float_divider_seq_if.slave bus
);

`ifdef FDIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [4:0] CNT_LAST = 5'(ITER / STEPS - 1);

    fdiv_state_e             state;
    logic [31:0]             a, b;
    logic                    sz;
    logic [23:0]             mb;
    logic [ITER-1:0]         rem, q;
    logic signed [EXP_W-1:0] e;
    logic                    sticky;
    logic [4:0]              cnt;

    logic [ITER-1:0] div, rem_d, q_d, rem1;
    logic            q1;

    assign div = ITER'(mb);

    fdiv_restoring_step #(.W(ITER)) u_step0 (
        .rem(rem), .div(div), .rem_nxt(rem1), .q(q1)
    );

`ifdef FDIV_RADIX4_EN
    logic [ITER-1:0] rem2;
    logic            q2;

    fdiv_restoring_step #(.W(ITER)) u_step1 (
        .rem(rem1), .div(div), .rem_nxt(rem2), .q(q2)
    );

    assign rem_d = rem2;
    assign q_d   = {q[ITER-3:0], q1, q2};
`else
    assign rem_d = rem1;
    assign q_d   = {q[ITER-2:0], q1};
`endif

    logic        sz_c, special;
    logic [31:0] spec_z;

    always_comb begin
        sz_c    = a[31] ^ b[31];
        special = 1'b1;
        spec_z  = '0;
        if (is_nan(a))                     spec_z = a;
        else if (is_nan(b))                spec_z = b;
        else if (is_inf(a) && is_inf(b))   spec_z = FP_NEG_QNAN;
        else if (is_zero(a) && is_zero(b)) spec_z = FP_NEG_QNAN;
        else if (is_inf(a))                spec_z = {sz_c, FP_INF[30:0]};
        else if (is_inf(b))                spec_z = {sz_c, 31'd0};
        else if (is_zero(a))               spec_z = {sz_c, 31'd0};
        else if (is_zero(b))               spec_z = {sz_c, FP_INF[30:0]};
        else                               special = 1'b0;
    end

    // Subnormal operands are left-justified with effective exponent 1-lz.
    logic [23:0]             ma_s, mb_s, ma_n, mb_n;
    logic [4:0]              lza, lzb;
    logic signed [EXP_W-1:0] ea_s, eb_s, e_s;

    always_comb begin
        ma_s = {|a[30:23], a[22:0]};
        mb_s = {|b[30:23], b[22:0]};
        lza  = lzc24(ma_s);
        lzb  = lzc24(mb_s);
        ma_n = ma_s << lza;
        mb_n = mb_s << lzb;
        ea_s = ((a[30:23] == 8'd0) ? EXP_W'(1) : EXP_W'(a[30:23]))
               - EXP_W'(lza);
        eb_s = ((b[30:23] == 8'd0) ? EXP_W'(1) : EXP_W'(b[30:23]))
               - EXP_W'(lzb);
        e_s  = ea_s - eb_s + EXP_W'(FP_BIAS);
    end

    logic [ITER-1:0]         q_n, mask;
    logic signed [EXP_W-1:0] e_n, sh;
    logic                    st_n;

    always_comb begin
        q_n  = q[ITER-1] ? q : q << 1;
        e_n  = q[ITER-1] ? e : e - EXP_W'(1);
        st_n = |rem;
        sh   = EXP_W'(1) - e_n;
        mask = '0;
        if (e_n[EXP_W-1] || e_n == '0) begin
            if (sh >= EXP_W'(ITER)) begin
                st_n = st_n | (|q_n);
                q_n  = '0;
            end else begin
                mask = ~({ITER{1'b1}} << sh[4:0]);
                st_n = st_n | (|(q_n & mask));
                q_n  = q_n >> sh[4:0];
            end
            e_n = '0;
        end
    end

    // Guard is q[1]; q[0] only matters as part of the sticky.
    logic [30:0] mag_r;
    logic [31:0] res_z;

    always_comb begin
        mag_r = round_to_nearest_even({e[7:0], q[ITER-2:2]},
                                      q[1], q[0] | sticky);
        if (e >= EXP_W'(255) || (&mag_r[30:23]))
            res_z = {sz, FP_INF[30:0]};
        else
            res_z = {sz, mag_r};
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= S_IDLE;
            a        <= '0;
            b        <= '0;
            sz       <= 1'b0;
            mb       <= '0;
            rem      <= '0;
            q        <= '0;
            e        <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            bus.fz   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a        <= bus.fa;
                        b        <= bus.fb;
                        bus.busy <= 1'b1;
                        state    <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    sz <= sz_c;
                    if (special) begin
                        bus.fz   <= spec_z;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    rem   <= ITER'(ma_n);
                    mb    <= mb_n;
                    e     <= e_s;
                    q     <= '0;
                    cnt   <= '0;
                    state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem <= rem_d;
                    q   <= q_d;
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST) state <= S_NORMALIZE;
                end
                S_NORMALIZE: begin
                    q      <= q_n;
                    e      <= e_n;
                    sticky <= st_n;
                    state  <= S_ROUND;
                end
                S_ROUND: begin
                    bus.fz   <= res_z;
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_divider_seq.sv
// tb_float_divider_seq: directed and random checks of float_divider_seq
// against a real-arithmetic quotient model; FDIV_RADIX4_EN aware.
module tb_float_divider_seq;
    import fpu_pkg::*;

`ifdef FDIV_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 31;
`endif
    localparam int NRAND = 1500;

    logic clk = 1'b0;
    logic clr;
    int   vectors = 0;
    int   miscompares = 0;

    float_divider_seq_if bus ();

    float_divider_seq dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) repeat (k) p = p * 2.0;
        else repeat (-k) p = p / 2.0;
        return p;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        if (f[30:23] == 8'd0)
            return real'(f[22:0]) * pow2(-149);
        return real'({1'b1, f[22:0]}) * pow2(int'(f[30:23]) - 150);
    endfunction

    // Exact double quotient, then round-to-nearest-even into binary32.
    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b);
        real    r, x, n, fl, frac;
        int     ex, eu;
        longint bits;
        logic   s;
        s = a[31] ^ b[31];
        r = f2r(a) / f2r(b);
        if (r == 0.0) return {s, 31'd0};
        x  = r;
        ex = 0;
        while (x >= 2.0) begin x = x / 2.0; ex++; end
        while (x < 1.0) begin x = x * 2.0; ex--; end
        eu   = (ex < -126) ? -126 : ex;
        n    = r * pow2(23 - eu);
        fl   = $floor(n);
        frac = n - fl;
        bits = longint'(fl);
        if (frac > 0.5 || (frac == 0.5 && bits[0])) bits++;
        bits = bits + (longint'(eu + 126) << 23);
        if (bits >= 64'sh7f800000) return {s, FP_INF[30:0]};
        return {s, bits[30:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] z, output int lat,
                          output int nb, output logic busy_after);
        @(negedge clk);
        bus.fa    = a;
        bus.fb    = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        nb  = 0;
        z   = 'x;
        for (int n = 1; n <= 64; n++) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                lat = n;
                z   = bus.fz;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        busy_after = bus.busy;
    endtask

    logic [31:0] da [10] = '{32'h40c00000, 32'h3f800000, 32'hbf800000,
                             32'h3f800000, 32'h7f800000, 32'h00000000,
                             32'h12345678, 32'h00800000, 32'h00000001,
                             32'h7f000000};
    logic [31:0] db [10] = '{32'h40000000, 32'h40400000, 32'h40400000,
                             32'h00000000, 32'hff800000, 32'h00000000,
                             32'h7fc00000, 32'h40000000, 32'h3f000000,
                             32'h3f000000};
    logic [31:0] dz [10] = '{32'h40400000, 32'h3eaaaaab, 32'hbeaaaaab,
                             32'h7f800000, 32'hffc00000, 32'hffc00000,
                             32'h7fc00000, 32'h00400000, 32'h00000002,
                             32'h7f800000};
    int          dl [10] = '{LAT, LAT, LAT, 2, 2, 2, 2, LAT, LAT, LAT};

    initial begin
        logic [31:0] z, a, b;
        int          lat, nb, dn;
        logic        ba;

        clr       = 1'b0;
        bus.start = 1'b0;
        bus.fa    = '0;
        bus.fb    = '0;
        repeat (3) @(negedge clk);
        check("reset_fz", bus.fz, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        clr = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(da[i], db[i], z, lat, nb, ba);
            check($sformatf("dir%0d_fz", i), z, dz[i]);
            check($sformatf("dir%0d_lat", i), lat, dl[i]);
            check($sformatf("dir%0d_busy", i), nb, dl[i]);
            check($sformatf("dir%0d_idle", i), 32'(ba), 32'd0);
        end

        // Extra starts mid-divide and during the done cycle are dropped.
        @(negedge clk);
        bus.fa    = 32'h40c00000;
        bus.fb    = 32'h40000000;
        bus.start = 1'b1;
        @(negedge clk);
        lat = -1;
        dn  = 0;
        for (int n = 1; n <= 64; n++) begin
            bus.start = 1'b0;
            if (bus.done) begin
                dn++;
                if (lat < 0) lat = n;
            end
            if (n == 5 || n == lat) begin
                bus.fa    = 32'h3f800000;
                bus.fb    = 32'h40400000;
                bus.start = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ign_done_cnt", dn, 32'd1);
        check("ign_lat", lat, LAT);
        check("ign_fz", bus.fz, 32'h40400000);
        check("ign_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.fa    = 32'h3f800000;
        bus.fb    = 32'h40400000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_fz", bus.fz, 32'h0);
        check("midrst_done", 32'(bus.done), 32'd0);
        clr = 1'b1;
        dn  = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("midrst_nodone", dn, 32'd0);

        for (int i = 0; i < NRAND; i++) begin
            a = {1'($urandom), 8'($urandom_range(20, 234)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(20, 234)), 23'($urandom)};
            run_op(a, b, z, lat, nb, ba);
            check($sformatf("rnd%0d_%h_%h", i, a, b), z, ref_div(a, b));
            check($sformatf("rnd%0d_lat", i), lat, LAT);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
